// File: rtl/alu_reservation_station_pkg.sv
// Shared types for the ALU reservation station: ROB tags, operand slots, queue entries.
package alu_reservation_station_pkg;

  localparam int RS_DEPTH = 4;
  localparam int RS_TAG_W = 4;

  typedef logic [RS_TAG_W-1:0] RobTag;
  typedef logic [63:0]         MemoryWord;

  typedef struct packed {
    logic [3:0] aluop;
    logic       usign;
  } control_bits;

  typedef struct packed {
    logic      rdy;
    RobTag     tag;
    MemoryWord val;
  } rs_src_t;

  typedef struct packed {
    logic        valid;
    control_bits ctrl;
    RobTag       tag;
    rs_src_t     a;
    rs_src_t     b;
  } rs_entry_t;

endpackage

// File: rtl/rs_src_capture.sv
// One operand's CDB snoop: a waiting operand whose producer tag is broadcast captures the value.
// Purely combinational; an operand that is already ready is never overwritten.
module rs_src_capture
  import alu_reservation_station_pkg::*;
(
  input  rs_src_t   src,
  input  logic      cdb_valid,
  input  RobTag     cdb_tag,
  input  MemoryWord cdb_value,
  output rs_src_t   src_out
);

  always_comb begin
    src_out = src;
    if (!src.rdy && cdb_valid && (cdb_tag == src.tag)) begin
      src_out.rdy = 1'b1;
      src_out.val = cdb_value;
    end
  end

endmodule

// File: rtl/alu_reservation_station.sv
// Collapsing age-ordered reservation station feeding the ALU through a registered issue stage.
// Ready-at-dispatch ops issue two edges later; a stalled issue stage holds its op and the queue.
module alu_reservation_station
  import alu_reservation_station_pkg::*;
#(
  parameter int DEPTH = RS_DEPTH,
  parameter int TAG_W = RS_TAG_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       disp_valid,
  output logic                       disp_ready,
  input  control_bits                disp_ctrl,
  input  logic [TAG_W-1:0]           disp_tag,
  input  logic                       disp_a_rdy,
  input  logic [TAG_W-1:0]           disp_a_tag,
  input  logic [63:0]                disp_a_val,
  input  logic                       disp_b_rdy,
  input  logic [TAG_W-1:0]           disp_b_tag,
  input  logic [63:0]                disp_b_val,
  input  logic                       cdb_valid,
  input  logic [TAG_W-1:0]           cdb_tag,
  input  logic [63:0]                cdb_value,
  output logic                       iss_valid,
  input  logic                       iss_ready,
  output control_bits                iss_ctrl,
  output logic [TAG_W-1:0]           iss_tag,
  output logic [63:0]                iss_a,
  output logic [63:0]                iss_b,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int OCC_W = $clog2(DEPTH+1);

  rs_entry_t        q     [DEPTH];
  rs_entry_t        q_ext [DEPTH+1];
  rs_entry_t        q_nxt [DEPTH];
  rs_src_t          wk_a  [DEPTH];
  rs_src_t          wk_b  [DEPTH];
  rs_entry_t        disp_entry;
  rs_src_t          disp_a_src, disp_b_src;
  logic [OCC_W-1:0] occ, occ_nxt, wr_idx, sel_idx;
  logic             sel_found, load, take, disp_fire;
  control_bits      sel_ctrl;
  RobTag            sel_tag;
  MemoryWord        sel_a, sel_b;

  assign occupancy  = occ;
  assign disp_ready = (occ < OCC_W'(DEPTH));
  assign disp_fire  = disp_valid && disp_ready;
  assign load       = !iss_valid || iss_ready;
  assign take       = load && sel_found;
  assign wr_idx     = occ - OCC_W'(take);
  assign occ_nxt    = occ + OCC_W'(disp_fire) - OCC_W'(take);

  for (genvar i = 0; i < DEPTH; i++) begin : g_wake
    rs_src_capture u_cap_a (.src(q[i].a), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
                            .cdb_value(cdb_value), .src_out(wk_a[i]));
    rs_src_capture u_cap_b (.src(q[i].b), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
                            .cdb_value(cdb_value), .src_out(wk_b[i]));
  end

  // Same-cycle CDB bypass so a dispatching op never misses its producer's broadcast.
  rs_src_capture u_disp_a (.src('{rdy: disp_a_rdy, tag: disp_a_tag, val: disp_a_val}),
                           .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
                           .src_out(disp_a_src));
  rs_src_capture u_disp_b (.src('{rdy: disp_b_rdy, tag: disp_b_tag, val: disp_b_val}),
                           .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
                           .src_out(disp_b_src));

  always_comb begin
    disp_entry       = '0;
    disp_entry.valid = 1'b1;
    disp_entry.ctrl  = disp_ctrl;
    disp_entry.tag   = disp_tag;
    disp_entry.a     = disp_a_src;
    disp_entry.b     = disp_b_src;
  end

  // Oldest-first select on registered ready bits: scan downward so the lowest slot wins.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_ctrl  = '0;
    sel_tag   = '0;
    sel_a     = '0;
    sel_b     = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (q[i].valid && q[i].a.rdy && q[i].b.rdy) begin
        sel_found = 1'b1;
        sel_idx   = OCC_W'(i);
        sel_ctrl  = q[i].ctrl;
        sel_tag   = q[i].tag;
        sel_a     = q[i].a.val;
        sel_b     = q[i].b.val;
      end
    end
  end

  always_comb begin
    for (int i = 0; i <= DEPTH; i++) q_ext[i] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      q_ext[i]   = q[i];
      q_ext[i].a = wk_a[i];
      q_ext[i].b = wk_b[i];
    end
    for (int i = 0; i < DEPTH; i++) begin
      q_nxt[i] = (take && (OCC_W'(i) >= sel_idx)) ? q_ext[i+1] : q_ext[i];
      if (disp_fire && (OCC_W'(i) == wr_idx)) q_nxt[i] = disp_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
      occ       <= '0;
      iss_valid <= 1'b0;
      iss_ctrl  <= '0;
      iss_tag   <= '0;
      iss_a     <= '0;
      iss_b     <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
      occ       <= '0;
      iss_valid <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) q[i] <= q_nxt[i];
      occ <= occ_nxt;
      if (load) begin
        iss_valid <= sel_found;
        if (sel_found) begin
          iss_ctrl <= sel_ctrl;
          iss_tag  <= sel_tag;
          iss_a    <= sel_a;
          iss_b    <= sel_b;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_reservation_station.sv
// Scoreboard bench: expected issues queued at dispatch in required issue order, checked at handshake.
module tb_alu_reservation_station;
  import alu_reservation_station_pkg::*;

  typedef struct {
    logic [3:0]  tag;
    logic [63:0] a;
    logic [63:0] b;
    control_bits ctrl;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, flush, disp_valid, disp_ready;
  control_bits disp_ctrl, iss_ctrl;
  logic [3:0]  disp_tag, disp_a_tag, disp_b_tag, cdb_tag, iss_tag;
  logic        disp_a_rdy, disp_b_rdy, cdb_valid, iss_valid, iss_ready;
  logic [63:0] disp_a_val, disp_b_val, cdb_value, iss_a, iss_b;
  logic [2:0]  occupancy;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  alu_reservation_station dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_ctrl(disp_ctrl), .disp_tag(disp_tag),
    .disp_a_rdy(disp_a_rdy), .disp_a_tag(disp_a_tag), .disp_a_val(disp_a_val),
    .disp_b_rdy(disp_b_rdy), .disp_b_tag(disp_b_tag), .disp_b_val(disp_b_val),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_ctrl(iss_ctrl), .iss_tag(iss_tag),
    .iss_a(iss_a), .iss_b(iss_b), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic control_bits ctrl_of(input logic [3:0] tag);
    control_bits c;
    c.aluop = tag ^ 4'h5;
    c.usign = tag[0];
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] tag, input logic [63:0] a, input logic [63:0] b);
    exp_t e;
    e.tag  = tag;
    e.a    = a;
    e.b    = b;
    e.ctrl = ctrl_of(tag);
    sb.push_back(e);
  endtask

  task automatic dispatch(input logic [3:0] tag,
                          input logic ardy, input logic [3:0] atag, input logic [63:0] aval,
                          input logic brdy, input logic [3:0] btag, input logic [63:0] bval);
    disp_valid = 1'b1;
    disp_ctrl  = ctrl_of(tag);
    disp_tag   = tag;
    disp_a_rdy = ardy;
    disp_a_tag = atag;
    disp_a_val = aval;
    disp_b_rdy = brdy;
    disp_b_tag = btag;
    disp_b_val = bval;
    tick();
    disp_valid = 1'b0;
  endtask

  task automatic cdb(input logic [3:0] tag, input logic [63:0] value);
    cdb_valid = 1'b1;
    cdb_tag   = tag;
    cdb_value = value;
    tick();
    cdb_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && iss_valid && iss_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_issue_tag", 64'(iss_tag), 64'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_tag", 64'(iss_tag), 64'(e.tag));
        chk("sb_a", iss_a, e.a);
        chk("sb_b", iss_b, e.b);
        chk("sb_ctrl", 64'(iss_ctrl), 64'(e.ctrl));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; disp_valid = 1'b0; disp_ctrl = '0; disp_tag = '0;
    disp_a_rdy = 1'b0; disp_a_tag = '0; disp_a_val = '0;
    disp_b_rdy = 1'b0; disp_b_tag = '0; disp_b_val = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0; iss_ready = 1'b1;
    repeat (3) tick();
    chk("rst_iss_valid", 64'(iss_valid), 64'd0);
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    chk("rst_iss_a", iss_a, 64'd0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_disp_ready", 64'(disp_ready), 64'd1);

    // 1: both operands ready at dispatch
    push(4'd3, 64'd5, 64'd7);
    dispatch(4'd3, 1'b1, 4'd0, 64'd5, 1'b1, 4'd0, 64'd7);
    chk("t1_no_issue_e0", 64'(iss_valid), 64'd0);
    chk("t1_occ_e0", 64'(occupancy), 64'd1);
    tick();
    chk("t1_iss_valid_e1", 64'(iss_valid), 64'd1);
    chk("t1_iss_tag", 64'(iss_tag), 64'd3);
    tick();
    chk("t1_drained", 64'(iss_valid), 64'd0);
    chk("t1_occ_end", 64'(occupancy), 64'd0);

    // 2: operand A woken by CDB
    push(4'd4, 64'h1234, 64'd1);
    dispatch(4'd4, 1'b0, 4'd9, 64'd0, 1'b1, 4'd0, 64'd1);
    repeat (3) tick();
    chk("t2_waiting", 64'(iss_valid), 64'd0);
    cdb(4'd9, 64'h1234);
    chk("t2_not_yet_ew", 64'(iss_valid), 64'd0);
    tick();
    chk("t2_issued", 64'(iss_valid), 64'd1);
    chk("t2_iss_a", iss_a, 64'h1234);
    tick();

    // 3: dispatch-cycle CDB bypass
    push(4'd6, 64'hAA, 64'h55);
    cdb_valid = 1'b1; cdb_tag = 4'd2; cdb_value = 64'hAA;
    dispatch(4'd6, 1'b0, 4'd2, 64'd0, 1'b1, 4'd0, 64'h55);
    cdb_valid = 1'b0;
    chk("t3_no_issue_e0", 64'(iss_valid), 64'd0);
    tick();
    chk("t3_issued", 64'(iss_valid), 64'd1);
    chk("t3_iss_a", iss_a, 64'hAA);
    tick();

    // 4: full queue backpressure
    for (int k = 0; k < 4; k++) begin
      push(4'(10 + k), 64'(16'h100 + k), 64'(k));
      dispatch(4'(10 + k), 1'b0, 4'(k), 64'd0, 1'b1, 4'd0, 64'(k));
    end
    chk("t4_occ_full", 64'(occupancy), 64'd4);
    chk("t4_disp_ready_full", 64'(disp_ready), 64'd0);
    dispatch(4'd15, 1'b1, 4'd0, 64'd1, 1'b1, 4'd0, 64'd2);
    chk("t4_occ_after_drop", 64'(occupancy), 64'd4);
    cdb(4'd0, 64'h100);
    chk("t4_still_full", 64'(disp_ready), 64'd0);
    tick();
    chk("t4_occ_after_issue", 64'(occupancy), 64'd3);
    chk("t4_disp_ready_again", 64'(disp_ready), 64'd1);
    chk("t4_iss_tag", 64'(iss_tag), 64'd10);
    for (int k = 1; k < 4; k++) cdb(4'(k), 64'(16'h100 + k));
    repeat (4) tick();
    chk("t4_occ_end", 64'(occupancy), 64'd0);

    // 5: two waiters on one producer issue oldest first
    push(4'd1, 64'h77, 64'd2);
    push(4'd2, 64'd3, 64'h77);
    dispatch(4'd1, 1'b0, 4'd7, 64'd0, 1'b1, 4'd0, 64'd2);
    dispatch(4'd2, 1'b1, 4'd0, 64'd3, 1'b0, 4'd7, 64'd0);
    cdb(4'd7, 64'h77);
    tick();
    chk("t5_first_tag", 64'(iss_tag), 64'd1);
    tick();
    chk("t5_second_tag", 64'(iss_tag), 64'd2);
    tick();

    // 6: stall holds the issue stage, then flush squashes everything
    iss_ready = 1'b0;
    dispatch(4'd5, 1'b1, 4'd0, 64'h11, 1'b1, 4'd0, 64'h22);
    dispatch(4'd8, 1'b1, 4'd0, 64'h33, 1'b1, 4'd0, 64'h44);
    for (int k = 0; k < 3; k++) begin
      chk("t6_hold_valid", 64'(iss_valid), 64'd1);
      chk("t6_hold_tag", 64'(iss_tag), 64'd5);
      chk("t6_hold_a", iss_a, 64'h11);
      chk("t6_hold_occ", 64'(occupancy), 64'd1);
      tick();
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t6_flush_valid", 64'(iss_valid), 64'd0);
    chk("t6_flush_occ", 64'(occupancy), 64'd0);
    iss_ready = 1'b1;
    repeat (4) tick();
    chk("t6_still_idle", 64'(iss_valid), 64'd0);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
